// File: rtl/icache_pkg.sv
// Shared types, widths and state encodings for the direct-mapped instruction cache.
package icache_pkg;
    localparam int INST_ADDR_W       = 32;
    localparam int INST_W            = 32;
    localparam int ICACHE_INDEX_BITS = 7;
    localparam int ICACHE_ADDR_BITS  = 18;

    typedef enum logic [1:0] {
        ICACHE_IDLE = 2'd0,
        ICACHE_MISS = 2'd1,
        ICACHE_RESP = 2'd2
    } icache_state_e;
endpackage

// File: rtl/icache_ram.sv
// Data + tag line storage: synchronous write, asynchronous read, no reset so it maps onto LUTRAM.
module icache_ram
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = ICACHE_ADDR_BITS - ICACHE_INDEX_BITS - 2
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] waddr_i,
    input  logic [INST_W-1:0]     wdata_i,
    input  logic [TAG_BITS-1:0]   wtag_i,
    input  logic [INDEX_BITS-1:0] raddr_i,
    output logic [INST_W-1:0]     rdata_o,
    output logic [TAG_BITS-1:0]   rtag_o
);
    localparam int DEPTH = 1 << INDEX_BITS;

    logic [INST_W-1:0]   data_q [DEPTH];
    logic [TAG_BITS-1:0] tag_q  [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            data_q[waddr_i] <= wdata_i;
            tag_q[waddr_i]  <= wtag_i;
        end
    end

    assign rdata_o = data_q[raddr_i];
    assign rtag_o  = tag_q[raddr_i];
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: zero-wait hits, single-word refill on a miss,
// fill forwarded to IF in the RESP cycle when the PC still matches.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int ADDR_BITS  = ICACHE_ADDR_BITS
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rdy_i,
    input  logic                   if_req_i,
    input  logic [INST_ADDR_W-1:0] if_addr_i,
    output logic                   if_valid_o,
    output logic [INST_W-1:0]      if_inst_o,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic                   mem_done_i,
    input  logic [INST_W-1:0]      mem_inst_i,
    input  logic                   inv_i,
    output logic [31:0]            hit_cnt_o,
    output logic [31:0]            miss_cnt_o
);
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;

    icache_state_e          state_q;
    logic [LINES-1:0]       valid_q;
    logic                   abandon_q;
    logic                   mem_req_q;
    logic [INST_ADDR_W-1:0] mem_addr_q;
    logic [INST_W-1:0]      fill_q;
    logic                   if_valid_q;
    logic [INST_W-1:0]      if_inst_q;
    logic [31:0]            hit_cnt_q;
    logic [31:0]            miss_cnt_q;

    logic                   if_valid_d;
    logic [INST_W-1:0]      if_inst_d;

    logic [INDEX_BITS-1:0]  idx;
    logic [TAG_BITS-1:0]    tag;
    logic [INDEX_BITS-1:0]  miss_idx;
    logic [TAG_BITS-1:0]    miss_tag;
    logic [INST_W-1:0]      rd_data;
    logic [TAG_BITS-1:0]    rd_tag;
    logic                   hit;
    logic                   lookup_hit;
    logic                   fwd;
    logic                   fill_we;
    logic                   unused_addr_lsbs;

    assign idx              = if_addr_i[INDEX_BITS+1:2];
    assign tag              = if_addr_i[ADDR_BITS-1:INDEX_BITS+2];
    assign miss_idx         = mem_addr_q[INDEX_BITS+1:2];
    assign miss_tag         = mem_addr_q[ADDR_BITS-1:INDEX_BITS+2];
    assign unused_addr_lsbs = ^if_addr_i[1:0];

    // The fill still writes data/tag when abandoned; only the valid bit is withheld.
    assign fill_we = !rst_i && rdy_i && (state_q == ICACHE_MISS) && mem_done_i;

    icache_ram #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (fill_we),
        .waddr_i (miss_idx),
        .wdata_i (mem_inst_i),
        .wtag_i  (miss_tag),
        .raddr_i (idx),
        .rdata_o (rd_data),
        .rtag_o  (rd_tag)
    );

    assign hit        = valid_q[idx] && (rd_tag == tag) && !inv_i;
    assign lookup_hit = (state_q == ICACHE_IDLE) && if_req_i && hit;
    assign fwd        = (state_q == ICACHE_RESP) && if_req_i && !abandon_q &&
                        (if_addr_i[ADDR_BITS-1:2] == mem_addr_q[ADDR_BITS-1:2]);

    always_comb begin
        if_valid_d = 1'b0;
        if_inst_d  = '0;
        if (!rst_i) begin
            if (lookup_hit) begin
                if_valid_d = 1'b1;
                if_inst_d  = rd_data;
            end else if (fwd) begin
                if_valid_d = 1'b1;
                if_inst_d  = fill_q;
            end
        end
    end

    // While stalled the IF side sees the last values it was given.
    assign if_valid_o = (rdy_i || rst_i) ? if_valid_d : if_valid_q;
    assign if_inst_o  = (rdy_i || rst_i) ? if_inst_d  : if_inst_q;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ICACHE_IDLE;
            valid_q    <= '0;
            abandon_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            fill_q     <= '0;
            if_valid_q <= 1'b0;
            if_inst_q  <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy_i) begin
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            if (inv_i) begin
                valid_q <= '0;
            end
            unique case (state_q)
                ICACHE_IDLE: begin
                    if (if_req_i) begin
                        if (hit) begin
                            hit_cnt_q <= hit_cnt_q + 32'd1;
                        end else begin
                            mem_addr_q <= {if_addr_i[INST_ADDR_W-1:2], 2'b00};
                            mem_req_q  <= 1'b1;
                            miss_cnt_q <= miss_cnt_q + 32'd1;
                            state_q    <= ICACHE_MISS;
                        end
                    end
                end
                ICACHE_MISS: begin
                    if (inv_i) begin
                        abandon_q <= 1'b1;
                    end
                    if (mem_done_i) begin
                        if (!inv_i && !abandon_q) begin
                            valid_q[miss_idx] <= 1'b1;
                        end
                        fill_q    <= mem_inst_i;
                        mem_req_q <= 1'b0;
                        state_q   <= ICACHE_RESP;
                    end
                end
                ICACHE_RESP: begin
                    abandon_q <= 1'b0;
                    state_q   <= ICACHE_IDLE;
                end
                default: state_q <= ICACHE_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed table, hand sequences for redirect/invalidate/stall, random fetches vs a line model.
module tb_icache;
    logic        clk = 1'b0;
    logic        rst, rdy, if_req, mem_done, inv;
    logic [31:0] if_addr, mem_inst;
    logic        if_valid, mem_req;
    logic [31:0] if_inst, mem_addr, hit_cnt, miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int ctrl_lat = 5;

    always #5 clk = ~clk;

    icache dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rdy_i      (rdy),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_valid_o (if_valid),
        .if_inst_o  (if_inst),
        .mem_req_o  (mem_req),
        .mem_addr_o (mem_addr),
        .mem_done_i (mem_done),
        .mem_inst_i (mem_inst),
        .inv_i      (inv),
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
    );

    // Backing memory contents depend only on the significant word address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[17:2], 16'h0000} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory controller: answers ctrl_lat ready-cycles after first seeing mem_req, frozen by rdy.
    initial begin : ctrl
        bit          pending;
        int          cnt;
        logic [31:0] a;
        pending  = 1'b0;
        cnt      = 0;
        a        = '0;
        mem_done = 1'b0;
        mem_inst = '0;
        forever begin
            @(posedge clk);
            #3;
            mem_done = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else if (rdy) begin
                if (pending) begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_done = 1'b1;
                        mem_inst = word_of(a);
                        pending  = 1'b0;
                    end
                end else if (mem_req) begin
                    pending = 1'b1;
                    cnt     = ctrl_lat;
                    a       = mem_addr;
                end
            end
        end
    end

    // One IF fetch; cycles counts clocks from the request cycle to the valid cycle.
    task automatic fetch(input logic [31:0] addr, input int stall_at, input int stall_len,
                         output logic hit, output logic [31:0] inst, output int cycles,
                         output logic hold_ok, output logic done_ok);
        logic [31:0] mc;
        hit = 1'b0; inst = '0; cycles = -1; hold_ok = 1'b1; done_ok = 1'b0; mc = '0;
        tick();
        if_req = 1'b1; if_addr = addr; rdy = 1'b1; inv = 1'b0;
        @(negedge clk);
        if (if_valid) begin
            hit = 1'b1; inst = if_inst; cycles = 0; done_ok = 1'b1;
            if (mem_req) hold_ok = 1'b0;
            return;
        end
        for (int n = 1; n <= 60; n++) begin
            tick();
            rdy = !(n >= stall_at && n < stall_at + stall_len);
            @(negedge clk);
            if (n == 1) mc = miss_cnt;
            if (mem_req && mem_addr !== {addr[31:2], 2'b00}) hold_ok = 1'b0;
            if (miss_cnt !== mc) hold_ok = 1'b0;
            if (rdy && if_valid) begin
                inst = if_inst; cycles = n; done_ok = 1'b1;
                break;
            end
        end
        rdy = 1'b1;
    endtask

    task automatic idle_and_check_counts(input int exp_hits, input int exp_misses);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        check("hit_cnt", hit_cnt, 32'(exp_hits));
        check("miss_cnt", miss_cnt, 32'(exp_misses));
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_addr = '0; inv = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        int          lat;
        logic        exp_hit;
        int          exp_hits;
        int          exp_misses;
    } vec_t;

    vec_t vecs[11];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic        hit, hold_ok, done_ok, spur, got;
        logic [31:0] inst, a;
        int          cycles, lat, s_at, s_len, t, ix, exp_hits, exp_misses;
        logic        exp_hit;
        bit          m_valid[128];
        int          m_tag[128];

        vecs[0]  = '{32'h0000_0000, 5, 1'b0, 0, 1};
        vecs[1]  = '{32'h0000_0000, 5, 1'b1, 1, 1};
        vecs[2]  = '{32'h0000_0200, 3, 1'b0, 1, 2};
        vecs[3]  = '{32'h0000_0000, 1, 1'b0, 1, 3};
        vecs[4]  = '{32'h0000_0000, 1, 1'b1, 2, 3};
        vecs[5]  = '{32'h0004_0000, 1, 1'b1, 3, 3};
        vecs[6]  = '{32'h0000_0002, 1, 1'b1, 4, 3};
        vecs[7]  = '{32'h0000_01FC, 6, 1'b0, 4, 4};
        vecs[8]  = '{32'h0000_03FC, 2, 1'b0, 4, 5};
        vecs[9]  = '{32'h0000_01FC, 4, 1'b0, 4, 6};
        vecs[10] = '{32'h0000_03FC, 1, 1'b0, 4, 7};

        do_reset();
        @(negedge clk);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);

        for (int i = 0; i < 11; i++) begin
            ctrl_lat = vecs[i].lat;
            fetch(vecs[i].addr, 100, 0, hit, inst, cycles, hold_ok, done_ok);
            check($sformatf("vec%0d_hit", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
            check($sformatf("vec%0d_done", i), {31'd0, done_ok}, 32'd1);
            check($sformatf("vec%0d_inst", i), inst, word_of(vecs[i].addr));
            check($sformatf("vec%0d_memaddr", i), {31'd0, hold_ok}, 32'd1);
            if (!vecs[i].exp_hit)
                check($sformatf("vec%0d_latency", i), 32'(cycles), 32'(vecs[i].lat + 2));
            idle_and_check_counts(vecs[i].exp_hits, vecs[i].exp_misses);
        end

        // Outputs hold while rdy is low, and the hit is counted once.
        fetch(32'h0000_0000, 100, 0, hit, inst, cycles, hold_ok, done_ok);
        check("hold_hit", {31'd0, hit}, 32'd1);
        tick();
        if_req = 1'b0; rdy = 1'b0;
        @(negedge clk);
        check("hold_if_valid", {31'd0, if_valid}, 32'd1);
        check("hold_if_inst", if_inst, 32'h0000_0013);
        tick();
        rdy = 1'b1;
        @(negedge clk);
        check("release_if_valid", {31'd0, if_valid}, 32'd0);
        check("hold_hit_cnt", hit_cnt, 32'd5);

        // Branch redirect while the refill of 0x104 is outstanding.
        ctrl_lat = 5;
        spur = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0104;
        @(negedge clk);
        if (if_valid) spur = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (n == 2) if_addr = 32'h0000_0300;
            @(negedge clk);
            if (if_valid) spur = 1'b1;
        end
        check("redirect_no_valid", {31'd0, spur}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        check("redirect_new_req", {31'd0, mem_req}, 32'd1);
        check("redirect_new_addr", mem_addr, 32'h0000_0300);
        got = 1'b0; inst = '0;
        for (int n = 0; n < 30; n++) begin
            if (if_valid) begin got = 1'b1; inst = if_inst; break; end
            tick();
            @(negedge clk);
        end
        check("redirect_fill_done", {31'd0, got}, 32'd1);
        check("redirect_fill_inst", inst, word_of(32'h0000_0300));
        fetch(32'h0000_0104, 100, 0, hit, inst, cycles, hold_ok, done_ok);
        check("redirect_line_hit", {31'd0, hit}, 32'd1);
        check("redirect_line_inst", inst, word_of(32'h0000_0104));
        idle_and_check_counts(6, 9);

        // Invalidate coincident with mem_done abandons the fill.
        ctrl_lat = 3;
        spur = 1'b0; got = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0408;
        @(negedge clk);
        if (if_valid) spur = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            #3;
            if (mem_done) begin inv = 1'b1; got = 1'b1; end
            @(negedge clk);
            if (if_valid) spur = 1'b1;
            if (got) break;
        end
        tick();
        inv = 1'b0;
        @(negedge clk);
        if (if_valid) spur = 1'b1;
        check("inv_saw_done", {31'd0, got}, 32'd1);
        check("inv_no_valid", {31'd0, spur}, 32'd0);
        fetch(32'h0000_0408, 100, 0, hit, inst, cycles, hold_ok, done_ok);
        check("inv_refetch_miss", {31'd0, hit}, 32'd0);
        check("inv_refetch_inst", inst, word_of(32'h0000_0408));
        idle_and_check_counts(6, 11);

        // rdy low for 3 cycles mid-miss.
        ctrl_lat = 5;
        fetch(32'h0000_0C00, 2, 3, hit, inst, cycles, hold_ok, done_ok);
        check("stall_miss", {31'd0, hit}, 32'd0);
        check("stall_hold", {31'd0, hold_ok}, 32'd1);
        check("stall_latency", 32'(cycles), 32'd10);
        check("stall_inst", inst, word_of(32'h0000_0C00));
        idle_and_check_counts(6, 12);

        // Random fetches against a line-level model.
        do_reset();
        for (int i = 0; i < 128; i++) begin m_valid[i] = 1'b0; m_tag[i] = 0; end
        exp_hits = 0; exp_misses = 0;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                tick();
                if_req = 1'b0; inv = 1'b1;
                tick();
                inv = 1'b0;
                for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
            end
            t  = int'($urandom_range(0, 3));
            ix = int'($urandom_range(0, 15));
            a  = ($urandom() & 32'hFFFC_0000) | (32'(t) << 9) | (32'(ix) << 2) | 32'($urandom_range(0, 3));
            lat   = int'($urandom_range(1, 6));
            s_at  = int'($urandom_range(1, 8));
            s_len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            exp_hit = m_valid[ix] && (m_tag[ix] == t);
            ctrl_lat = lat;
            fetch(a, s_at, s_len, hit, inst, cycles, hold_ok, done_ok);
            check("rnd_hit", {31'd0, hit}, {31'd0, exp_hit});
            check("rnd_done", {31'd0, done_ok}, 32'd1);
            check("rnd_inst", inst, word_of(a));
            check("rnd_hold", {31'd0, hold_ok}, 32'd1);
            if (exp_hit) begin
                exp_hits++;
            end else begin
                check("rnd_latency", 32'(cycles), 32'(lat + 2 + ((s_at <= lat + 2) ? s_len : 0)));
                exp_misses++;
                m_valid[ix] = 1'b1;
                m_tag[ix]   = t;
            end
        end
        idle_and_check_counts(exp_hits, exp_misses);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
